// File: rtl/ffn_stream_pkg.sv
// Shared types and helpers for the feed_forward_node operand streamer.
package ffn_stream_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STREAM      = 2'd1,
        WAIT_RESULT = 2'd2
    } state_t;

    localparam logic WR_SEL_DATA   = 1'b0;
    localparam logic WR_SEL_WEIGHT = 1'b1;

    // One beat per input/weight pair plus the trailing bias beat.
    function automatic int unsigned beat_count(input int unsigned n);
        return n + 1;
    endfunction

endpackage

// File: rtl/node_operand_buffer.sv
// Data/weight/bias register file with write-accept and range checking.
// Read ports are combinational; out-of-range reads return zero.
module node_operand_buffer
    import ffn_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned NUMBER_OF_INPUT_NODE = 2,
    parameter int unsigned ADDRESS_WIDTH        = $clog2(NUMBER_OF_INPUT_NODE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     idle,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data_c,
    output logic [DATA_WIDTH-1:0]    rd_weight_c,
    output logic                     wr_err
);

    localparam int unsigned N = NUMBER_OF_INPUT_NODE;
    localparam logic [ADDRESS_WIDTH-1:0] MAX_DATA_ADDR_EXCL = ADDRESS_WIDTH'(N);
    localparam logic [ADDRESS_WIDTH-1:0] BIAS_ADDR          = ADDRESS_WIDTH'(N);

    logic [DATA_WIDTH-1:0] data_q   [N];
    logic [DATA_WIDTH-1:0] weight_q [N+1];
    logic                  wr_err_q;
    logic                  in_range_c;
    logic                  accept_c;

    // Weight buffer has one extra slot for the bias.
    assign in_range_c = (wr_sel == WR_SEL_DATA) ? (wr_addr < MAX_DATA_ADDR_EXCL)
                                                : (wr_addr <= BIAS_ADDR);
    assign accept_c   = wr_en && idle && !start && in_range_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
            for (int unsigned i = 0; i <= N; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            wr_err_q <= wr_en && !accept_c;
            if (accept_c) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (wr_sel == WR_SEL_DATA && wr_addr == ADDRESS_WIDTH'(i)) begin
                        data_q[i] <= wr_data;
                    end
                end
                for (int unsigned i = 0; i <= N; i++) begin
                    if (wr_sel == WR_SEL_WEIGHT && wr_addr == ADDRESS_WIDTH'(i)) begin
                        weight_q[i] <= wr_data;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data_c   = '0;
        rd_weight_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rd_addr == ADDRESS_WIDTH'(i)) begin
                rd_data_c = data_q[i];
            end
        end
        for (int unsigned i = 0; i <= N; i++) begin
            if (rd_addr == ADDRESS_WIDTH'(i)) begin
                rd_weight_c = weight_q[i];
            end
        end
    end

    assign wr_err = wr_err_q;

endmodule

// File: rtl/feed_forward_node_streamer.sv
// Streams one input/weight vector plus bias into feed_forward_node and
// returns the node's result with a done pulse.
module feed_forward_node_streamer
    import ffn_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned NUMBER_OF_INPUT_NODE = 2,
    parameter int unsigned ADDRESS_WIDTH        = $clog2(NUMBER_OF_INPUT_NODE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic                     i_wr_sel,
    input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_start,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic [DATA_WIDTH-1:0]    o_weight,
    output logic                     o_last,
    input  logic                     i_result_valid,
    input  logic [DATA_WIDTH-1:0]    i_result,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic                     o_done,
    output logic                     o_busy,
    output logic                     o_wr_err
);

    localparam int unsigned BEATS = beat_count(NUMBER_OF_INPUT_NODE);
    localparam logic [ADDRESS_WIDTH-1:0] BIAS_IDX = ADDRESS_WIDTH'(BEATS - 1);

    state_t                   state_q, state_d;
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DATA_WIDTH-1:0]    weight_q, weight_d;
    logic                     last_q, last_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

    logic                     idle_c;
    logic [ADDRESS_WIDTH-1:0] rd_addr_c;
    logic [DATA_WIDTH-1:0]    rd_data_c;
    logic [DATA_WIDTH-1:0]    rd_weight_c;

    assign idle_c = (state_q == IDLE);
    // Look one beat ahead while streaming; in IDLE prefetch beat 0.
    assign rd_addr_c = (state_q == STREAM) ? cnt_q + ADDRESS_WIDTH'(1) : '0;

    node_operand_buffer #(
        .DATA_WIDTH          (DATA_WIDTH),
        .NUMBER_OF_INPUT_NODE(NUMBER_OF_INPUT_NODE),
        .ADDRESS_WIDTH       (ADDRESS_WIDTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (i_wr_en),
        .wr_sel     (i_wr_sel),
        .wr_addr    (i_wr_addr),
        .wr_data    (i_wr_data),
        .idle       (idle_c),
        .start      (i_start),
        .rd_addr    (rd_addr_c),
        .rd_data_c  (rd_data_c),
        .rd_weight_c(rd_weight_c),
        .wr_err     (o_wr_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            weight_q <= '0;
            last_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            weight_q <= weight_d;
            last_q   <= last_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        weight_d = weight_q;
        last_d   = last_q;
        result_d = result_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = STREAM;
                    valid_d  = 1'b1;
                    data_d   = rd_data_c;
                    weight_d = rd_weight_c;
                    last_d   = 1'b0;
                    cnt_d    = '0;
                end
            end
            STREAM: begin
                if (valid_q && i_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = WAIT_RESULT;
                    end else begin
                        // Bias beat: the data read port returns zero there.
                        cnt_d    = rd_addr_c;
                        data_d   = rd_data_c;
                        weight_d = rd_weight_c;
                        last_d   = (rd_addr_c == BIAS_IDX);
                    end
                end
            end
            WAIT_RESULT: begin
                if (i_result_valid) begin
                    result_d = i_result;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_weight = weight_q;
    assign o_last   = last_q;
    assign o_result = result_q;
    assign o_done   = done_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_feed_forward_node_streamer.sv
// Self-checking bench: reference model is the buffer contents plus the
// expected beat sequence they imply; stimulus is partly randomized.
module tb_feed_forward_node_streamer;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [DW-1:0] data;
    logic [DW-1:0] weight;
    logic          last;
    logic          result_valid = 1'b0;
    logic [DW-1:0] result = '0;
    logic [DW-1:0] res_out;
    logic          done;
    logic          busy;
    logic          wr_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_data   [N];
    logic [DW-1:0] m_weight [N+1];

    always #5 clk = ~clk;

    feed_forward_node_streamer #(
        .DATA_WIDTH(DW), .NUMBER_OF_INPUT_NODE(N), .ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_start(start), .i_ready(ready),
        .o_valid(valid), .o_data(data), .o_weight(weight), .o_last(last),
        .i_result_valid(result_valid), .i_result(result),
        .o_result(res_out), .o_done(done), .o_busy(busy), .o_wr_err(wr_err)
    );

    // Applies a write to the model when legal in IDLE; returns expected error.
    function automatic bit model_write(input logic sel, input int addr, input logic [DW-1:0] d);
        bit bad;
        bad = sel ? (addr > N) : (addr >= N);
        if (!bad) begin
            if (sel) m_weight[addr] = d;
            else     m_data[addr]   = d;
        end
        return bad;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_data[i] = '0;
        for (int i = 0; i <= N; i++) m_weight[i] = '0;
    endfunction

    // Expected beat k as {data, weight, last}.
    function automatic logic [2*DW:0] exp_beat(input int k);
        if (k < N) return {m_data[k], m_weight[k], 1'b0};
        return {{DW{1'b0}}, m_weight[N], 1'b1};
    endfunction

    // All tasks are entered and left on a falling edge.
    task automatic do_write(input logic sel, input int addr, input logic [DW-1:0] d,
                            output logic err_seen);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
        @(negedge clk);
        err_seen = wr_err;
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] b, output logic any_err);
        logic e;
        any_err = 1'b0;
        do_write(1'b0, 0, d0, e); any_err |= e; void'(model_write(1'b0, 0, d0));
        do_write(1'b0, 1, d1, e); any_err |= e; void'(model_write(1'b0, 1, d1));
        do_write(1'b1, 0, w0, e); any_err |= e; void'(model_write(1'b1, 0, w0));
        do_write(1'b1, 1, w1, e); any_err |= e; void'(model_write(1'b1, 1, w1));
        do_write(1'b1, 2, b,  e); any_err |= e; void'(model_write(1'b1, 2, b));
    endtask

    task automatic start_stream();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives i_ready and records transfers until all beats have gone out.
    task automatic collect_beats(input int stall_beat, input int stall_len, input bit rnd);
        int k = 0;
        int cyc = 0;
        int stalled = 0;
        bit prev_stall = 1'b0;
        logic r;
        logic [2*DW:0] prev, cur;
        while (k <= N && cyc < 200) begin
            cur = {data, weight, last};
            if (prev_stall) begin
                checks++;
                if (valid !== 1'b1 || cur !== prev) begin
                    errors++;
                    $display("FAIL hold_beat%0d: got v=%b %h want v=1 %h", k, valid, cur, prev);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_stream: got %b want 1", busy);
            end
            if (rnd) r = ($urandom_range(0, 2) != 0);
            else if (k == stall_beat && stalled < stall_len) begin r = 1'b0; stalled++; end
            else r = 1'b1;
            ready = r;
            if (valid === 1'b1 && r) begin
                checks++;
                if (cur !== exp_beat(k)) begin
                    errors++;
                    $display("FAIL beat%0d: got %h want %h", k, cur, exp_beat(k));
                end
                k++;
            end
            prev_stall = (valid === 1'b1) && !r;
            prev = cur;
            @(negedge clk);
            cyc++;
        end
        ready = 1'b0;
        checks++;
        if (k != N + 1) begin
            errors++;
            $display("FAIL transfer_count: got %0d want %0d", k, N + 1);
        end
        checks++;
        if (valid !== 1'b0 || last !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after_stream: got v=%b l=%b b=%b want 0 0 1", valid, last, busy);
        end
    endtask

    task automatic finish_result(input logic [DW-1:0] v);
        result_valid = 1'b1; result = v;
        @(negedge clk);
        result_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || res_out !== v || busy !== 1'b0) begin
            errors++;
            $display("FAIL result: got d=%b r=%h b=%b want 1 %h 0", done, res_out, busy, v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if ({valid, last, done, busy, wr_err} !== 5'b0 || data !== '0 || weight !== '0 || res_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b l=%b d=%b b=%b e=%b %h %h %h want zeros",
                     valid, last, done, busy, wr_err, data, weight, res_out);
        end
    endtask

    task automatic test_basic();
        logic e;
        load(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", e); end
        start_stream();
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency: got v=%b b=%b want 1 1", valid, busy);
        end
        collect_beats(-1, 0, 1'b0);
        finish_result(32'h41300000);
    endtask

    task automatic test_stall();
        start_stream();
        collect_beats(1, 2, 1'b0);
        finish_result(32'h40A00000);
    endtask

    task automatic test_wr_err();
        logic e;
        start_stream();
        do_write(1'b0, 0, 32'hDEADBEEF, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", e); end
        @(negedge clk);
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
        collect_beats(-1, 0, 1'b0);
        finish_result(32'h3F000000);
        do_write(1'b0, 2, 32'hBADBAD00, e);
        checks++;
        if (e !== model_write(1'b0, 2, 32'hBADBAD00)) begin errors++; $display("FAIL wr_data_range: got %b want 1", e); end
        do_write(1'b1, 3, 32'hBADBAD01, e);
        checks++;
        if (e !== model_write(1'b1, 3, 32'hBADBAD01)) begin errors++; $display("FAIL wr_weight_range: got %b want 1", e); end
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = AW'(0); wr_data = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        checks++;
        if (wr_err !== 1'b1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_with_start: got e=%b v=%b want 1 1", wr_err, valid);
        end
        collect_beats(-1, 0, 1'b0);
        finish_result(32'h12345678);
    endtask

    task automatic test_reset_mid();
        logic e;
        load($urandom, $urandom, $urandom, $urandom, $urandom, e);
        start_stream();
        ready = 1'b1;
        @(negedge clk);
        rst = 1'b1; ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== '0 || weight !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b b=%b %h %h want 0 0 0 0", valid, busy, data, weight);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet%0d: got d=%b v=%b want 0 0", i, done, valid);
            end
        end
        start_stream();
        collect_beats(-1, 0, 1'b0);
        finish_result(32'h00000001);
    endtask

    task automatic test_ignored();
        logic [DW-1:0] held;
        held = res_out;
        start_stream();
        result_valid = 1'b1; result = 32'h55555555;
        @(negedge clk);
        result_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || res_out !== held) begin
            errors++;
            $display("FAIL result_in_stream: got d=%b r=%h want 0 %h", done, res_out, held);
        end
        collect_beats(-1, 0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL start_in_wait: got b=%b v=%b e=%b want 1 0 0", busy, valid, wr_err);
        end
        finish_result(32'h3E800000);
        result_valid = 1'b1; result = 32'hAAAAAAAA;
        @(negedge clk);
        result_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || res_out !== 32'h3E800000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_in_idle: got d=%b r=%h b=%b want 0 3e800000 0", done, res_out, busy);
        end
    endtask

    task automatic test_random();
        logic e;
        logic [DW-1:0] d, rv;
        int addr;
        logic sel;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 8; w++) begin
                sel = 1'($urandom_range(0, 1));
                addr = $urandom_range(0, (1 << AW) - 1);
                d = $urandom;
                do_write(sel, addr, d, e);
                checks++;
                if (e !== model_write(sel, addr, d)) begin
                    errors++;
                    $display("FAIL rand_wr%0d_%0d: got %b sel=%b addr=%0d", it, w, e, sel, addr);
                end
            end
            start_stream();
            collect_beats(-1, 0, 1'b1);
            rv = $urandom;
            finish_result(rv);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_wr_err();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feed_forward_node_streamer.md
Name: feed_forward_node_streamer

Overview:
- Producer for `feed_forward_node`; it is the transmitter end of that node's serial `i_valid`/`i_data`/`i_weight` operand interface.
- A host or controller loads one input vector, one weight vector and one bias into local buffers. On `i_start` the block streams NUMBER_OF_INPUT_NODE+1 beats to the node; the final beat carries the bias.
- It then waits for the node's `o_valid`/`o_data` result and returns that result with a done pulse.

Parameters:
- DATA_WIDTH, 32, width of data, weight, bias and result words (IEEE-754 single).
- NUMBER_OF_INPUT_NODE, 2, number of input/weight pairs per node evaluation (N, N >= 1).
- ADDRESS_WIDTH, $clog2(NUMBER_OF_INPUT_NODE+1), buffer address and beat counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_wr_en  in  1  buffer write strobe.
- i_wr_sel  in  1  0 = data buffer, 1 = weight buffer (address N = bias).
- i_wr_addr  in  ADDRESS_WIDTH  buffer write index.
- i_wr_data  in  DATA_WIDTH  buffer write word.
- i_start  in  1  begin one node evaluation.
- i_ready  in  1  downstream accepts the current beat.
- o_valid  out  1  beat valid; drives node `i_valid`.
- o_data  out  DATA_WIDTH  beat data; drives node `i_data`.
- o_weight  out  DATA_WIDTH  beat weight or bias; drives node `i_weight`.
- o_last  out  1  high on the bias beat (beat index N).
- i_result_valid  in  1  node `o_valid`.
- i_result  in  DATA_WIDTH  node `o_data`.
- o_result  out  DATA_WIDTH  captured node result.
- o_done  out  1  one-cycle pulse when o_result updates.
- o_busy  out  1  high whenever state != IDLE.
- o_wr_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset state:
  - FSM in IDLE.
  - o_valid, o_last, o_done, o_busy and o_wr_err = 0.
  - o_data, o_weight and o_result = 0.
  - All buffer entries cleared to 0; beat counter = 0.
  - Reset asserted mid-stream or mid-wait aborts the operation immediately. No further beats and no o_done are produced.
- Buffers: data[0..N-1] and weight[0..N], where weight[N] is the bias.
  - A write is accepted only in IDLE with i_start low.
  - A data write with address >= N, or a weight write with address > N, is dropped and o_wr_err pulses.
  - A write while busy is dropped and o_wr_err pulses.
  - i_wr_en and i_start in the same IDLE cycle: the write is dropped, o_wr_err pulses, and the start proceeds on the old buffer contents.
- FSM states: IDLE, STREAM, WAIT_RESULT.
  - IDLE -> STREAM on i_start. At the same edge: o_valid=1, o_data=data[0], o_weight=weight[0], counter=0. First beat appears 1 cycle after i_start.
  - i_start while busy is ignored, with no error.
- STREAM transfer rule: a beat transfers when o_valid & i_ready.
  - While o_valid & !i_ready, o_data, o_weight and o_last hold stable.
  - On a transfer of beat k < N-1, the next beat is data[k+1]/weight[k+1].
  - On a transfer of beat N-1, the next beat is o_data=0, o_weight=weight[N], o_last=1.
  - On a transfer of beat N: o_valid=0, o_last=0, state -> WAIT_RESULT.
  - With i_ready held high, the N+1 beats are back-to-back.
- WAIT_RESULT: on i_result_valid, o_result<=i_result, o_done=1 for exactly one cycle, state -> IDLE, o_busy falls at the same edge.
  - i_result_valid in IDLE or STREAM is ignored.
  - There is no timeout.
- Counter: ADDRESS_WIDTH bits. It never wraps, because N+1 beats are the maximum.

Decomposition:
- Shared package `ffn_stream_pkg`:
  - State encoding localparams (IDLE=2'd0, STREAM=2'd1, WAIT_RESULT=2'd2).
  - WR_SEL_DATA/WR_SEL_WEIGHT constants.
  - Beat-count helper function (N+1).
- Sub-module `node_operand_buffer`: holds the data and weight register arrays and the write-accept/range check. Its outputs are a write-error pulse and combinational read ports indexed by the beat counter.
- The FSM and output registers stay in the top module.

Test Plan:
- N=2. Load data = {3F800000, 40000000}, weight = {40400000, 40800000}, bias 3F000000; pulse i_start with i_ready=1 -> 3 consecutive beats: (3F800000,40400000), (40000000,40800000), (00000000,3F000000) with o_last=1 on beat 3. First beat 1 cycle after start; o_busy=1 throughout.
- Same load; drop i_ready low for 2 cycles during beat 1 -> beat 1 held stable for those cycles, no beat skipped or duplicated, total transfers = 3.
- After the stream, drive i_result_valid=1 with i_result=41300000 -> o_result=41300000 and o_done high exactly 1 cycle; o_busy=0 in the same cycle.
- Write during STREAM, data write to address 2, and i_wr_en with i_start in the same cycle -> each case produces a one-cycle o_wr_err pulse and leaves buffer contents unchanged (checked by the next stream).
- Assert rst for 1 cycle mid-STREAM after beat 1 -> o_valid=0 next cycle, all buffers read 0, no o_done; a subsequent i_start streams three zero beats.
- i_start during WAIT_RESULT, and i_result_valid during IDLE -> both ignored; state and o_result are unchanged.
